mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32x32 unsigned multiplier among up to four requesters in the SoC. Each requester gets a one-hot grant and a one-hot done pulse. The block latches operands on grant and runs a fixed-latency multiply. It returns the 64-bit product on a shared, registered result bus.

---
 rtl/mul_arb_pkg.sv | 35 +++
 rtl/rr_pick.sv | 26 ++
 rtl/mul_arbiter.sv | 100 ++++++++++
 tb/tb_mul_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and the round-robin selection function for the multiplier arbiter.
// Pure definitions, no state and no flow control.
package mul_arb_pkg;

  typedef enum logic {IDLE, EXEC} state_t;

  localparam int OP_W    = 32;
  localparam int PROD_W  = 64;
  localparam int MAX_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 3;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scan starts one past the previous winner, so the last winner has lowest priority.
  function automatic pick_t rr_next(input logic [MAX_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   last,
                                    input int                 nreq = MAX_REQ);
    pick_t p;
    int    c;
    p = '0;
    for (int off = 1; off <= MAX_REQ; off++) begin
      c = (int'(last) + off) % nreq;
      if (off <= nreq && !p.vld && req[c[IDX_W-1:0]]) begin
        p.vld = 1'b1;
        p.idx = c[IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker; zero latency.
// No flow control: win_vld simply reflects whether any request is present.
module rr_pick
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  logic [MAX_REQ-1:0] req_ext;
  pick_t              pick;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
  end

  assign pick    = rr_next(req_ext, last, NREQ);
  assign win_idx = pick.idx;
  assign win_vld = pick.vld;

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one 32x32 multiplier; grant one cycle after sampling, result LAT edges after grant.
// Requests are ignored while an operation is in flight; requesters hold req until they see gnt.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*OP_W-1:0] a_in,
  input  logic [NREQ*OP_W-1:0] b_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [PROD_W-1:0]    y,
  output logic                 busy
);

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   id;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [CNT_W-1:0]   cnt;
  logic [OP_W-1:0]    op_a;
  logic [OP_W-1:0]    op_b;
  logic [OP_W-1:0]    a_sel;
  logic [OP_W-1:0]    b_sel;
  logic [PROD_W-1:0]  prod;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .last    (last),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        a_sel = a_in[i*OP_W +: OP_W];
        b_sel = b_in[i*OP_W +: OP_W];
      end
    end
  end

  // Multiplier settles from the operand registers; only the completion edge captures it.
  assign prod = {{(PROD_W-OP_W){1'b0}}, op_a} * {{(PROD_W-OP_W){1'b0}}, op_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      y     <= '0;
      op_a  <= '0;
      op_b  <= '0;
      id    <= '0;
      cnt   <= '0;
      last  <= IDX_W'(NREQ-1);
      busy  <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            op_a  <= a_sel;
            op_b  <= b_sel;
            id    <= win_idx;
            last  <= win_idx;
            cnt   <= CNT_W'(LAT-1);
            state <= EXEC;
            busy  <= 1'b1;
            for (int i = 0; i < NREQ; i++) gnt[i] <= (win_idx == IDX_W'(i));
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            y     <= prod;
            state <= IDLE;
            busy  <= 1'b0;
            for (int i = 0; i < NREQ; i++) done[i] <= (id == IDX_W'(i));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_gnt_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done));
  a_busy_state:  assert property (@(posedge clk) disable iff (!rst_n) busy == (state == EXEC));

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: one instance at NREQ=2/LAT=2, one at NREQ=3/LAT=4.
module tb_mul_arbiter;

  localparam int LA = 2;
  localparam int LB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n;
  logic [1:0]  req_a, gnt_a, done_a;
  logic [63:0] a_a, b_a, y_a;
  logic        busy_a;
  logic [2:0]  req_b, gnt_b, done_b;
  logic [95:0] a_b, b_b;
  logic [63:0] y_b;
  logic        busy_b;

  typedef struct {
    int          idx;
    logic [63:0] prod;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   vecs = 0;
  int   errs = 0;

  mul_arbiter #(.NREQ(2), .LAT(LA)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .req(req_a), .a_in(a_a), .b_in(b_a),
    .gnt(gnt_a), .done(done_a), .y(y_a), .busy(busy_a)
  );

  mul_arbiter #(.NREQ(3), .LAT(LB)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .req(req_b), .a_in(a_b), .b_in(b_b),
    .gnt(gnt_b), .done(done_b), .y(y_b), .busy(busy_b)
  );

  task automatic run_a(input int idx, input logic [31:0] av, input logic [31:0] bv, input string nm);
    exp_t       e;
    int         n;
    logic [1:0] eg;
    @(negedge clk);
    a_a[idx*32 +: 32] = av;
    b_a[idx*32 +: 32] = bv;
    req_a[idx]        = 1'b1;
    e.idx  = idx;
    e.prod = {32'b0, av} * {32'b0, bv};
    q_a.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (gnt_a == 2'b00 && n < 20);
    eg = 2'b01 << idx;
    vecs++;
    if (gnt_a !== eg || n != 1) begin
      errs++;
      $display("FAIL %s gnt: got %b after %0d cycles, want %b after 1", nm, gnt_a, n, eg);
    end
    req_a[idx] = 1'b0;
    vecs++;
    if (busy_a !== 1'b1) begin errs++; $display("FAIL %s busy_in_exec: got %b want 1", nm, busy_a); end
    n = 0;
    do begin @(negedge clk); n++; end while (done_a == 2'b00 && n < 20);
    e = q_a.pop_front();
    eg = 2'b01 << e.idx;
    vecs++;
    if (done_a !== eg || n != LA) begin
      errs++;
      $display("FAIL %s done: got %b after %0d cycles, want %b after %0d", nm, done_a, n, eg, LA);
    end
    vecs++;
    if (y_a !== e.prod) begin errs++; $display("FAIL %s y: got %h want %h", nm, y_a, e.prod); end
    vecs++;
    if (busy_a !== 1'b0) begin errs++; $display("FAIL %s busy_after_done: got %b want 0", nm, busy_a); end
  endtask

  task automatic test_reset;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    req_a = 2'($urandom);
    req_b = 3'($urandom);
    a_a = {$urandom, $urandom};
    b_a = {$urandom, $urandom};
    a_b = {$urandom, $urandom, $urandom};
    b_b = {$urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    vecs++;
    if ({gnt_a, done_a, busy_a} !== 5'b0 || y_a !== 64'd0) begin
      errs++;
      $display("FAIL reset_a: gnt=%b done=%b busy=%b y=%h want all 0", gnt_a, done_a, busy_a, y_a);
    end
    vecs++;
    if ({gnt_b, done_b, busy_b} !== 7'b0 || y_b !== 64'd0) begin
      errs++;
      $display("FAIL reset_b: gnt=%b done=%b busy=%b y=%h want all 0", gnt_b, done_b, busy_b, y_b);
    end
    req_a = '0;
    req_b = '0;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vecs++;
      if (gnt_a !== 2'b0 || done_a !== 2'b0 || busy_a !== 1'b0) begin
        errs++;
        $display("FAIL idle_a cycle %0d: gnt=%b done=%b busy=%b want 0", i, gnt_a, done_a, busy_a);
      end
      vecs++;
      if (gnt_b !== 3'b0 || done_b !== 3'b0 || busy_b !== 1'b0) begin
        errs++;
        $display("FAIL idle_b cycle %0d: gnt=%b done=%b busy=%b want 0", i, gnt_b, done_b, busy_b);
      end
    end
  endtask

  task automatic test_single;
    run_a(0, 32'd3, 32'd5, "single");
    repeat (10) @(negedge clk);
    vecs++;
    if (y_a !== 64'd15) begin errs++; $display("FAIL y_hold: got %h want 15", y_a); end
    vecs++;
    if (done_a !== 2'b00) begin errs++; $display("FAIL done_idle: got %b want 00", done_a); end
  endtask

  task automatic test_width;
    run_a(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "width_max");
    vecs++;
    if (y_a !== 64'hFFFF_FFFE_0000_0001) begin
      errs++; $display("FAIL width_max_const: got %h want fffffffe00000001", y_a);
    end
    run_a(0, 32'd0, 32'hFFFF_FFFF, "width_zero");
    vecs++;
    if (y_a !== 64'd0) begin errs++; $display("FAIL width_zero_const: got %h want 0", y_a); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) run_a(i % 2, $urandom, $urandom, "b2b");
  endtask

  task automatic test_withdrawal;
    exp_t e;
    @(negedge clk);
    a_a[31:0] = 32'd7;
    b_a[31:0] = 32'd9;
    req_a     = 2'b01;
    e.idx = 0; e.prod = 64'd63;
    q_a.push_back(e);
    @(negedge clk);
    vecs++;
    if (gnt_a !== 2'b01) begin errs++; $display("FAIL wd_gnt0: got %b want 01", gnt_a); end
    req_a = 2'b10;
    @(negedge clk);
    req_a = 2'b00;
    vecs++;
    if (gnt_a !== 2'b00) begin errs++; $display("FAIL wd_nogrant_exec: got %b want 00", gnt_a); end
    @(negedge clk);
    e = q_a.pop_front();
    vecs++;
    if (done_a !== 2'b01 || y_a !== e.prod) begin
      errs++; $display("FAIL wd_done: done=%b y=%h want 01 %h", done_a, y_a, e.prod);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (gnt_a !== 2'b00 || busy_a !== 1'b0) begin
        errs++; $display("FAIL wd_idle cycle %0d: gnt=%b busy=%b want 00 0", i, gnt_a, busy_a);
      end
    end
  endtask

  task automatic test_contention;
    exp_t       e;
    int         n;
    int         last_m;
    int         exp_idx;
    logic [2:0] eg;
    last_m = 2;
    for (int i = 0; i < 3; i++) begin
      a_b[i*32 +: 32] = $urandom | 32'd1;
      b_b[i*32 +: 32] = $urandom | 32'd1;
    end
    @(negedge clk);
    req_b = 3'b111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (gnt_b == 3'b0 && n < 30);
      exp_idx = (last_m + 1) % 3;
      last_m  = exp_idx;
      eg = 3'b001 << exp_idx;
      vecs++;
      if (gnt_b !== eg || (g > 0 && n != 1)) begin
        errs++; $display("FAIL cont_gnt %0d: got %b after %0d, want %b", g, gnt_b, n, eg);
      end
      e.idx  = exp_idx;
      e.prod = {32'b0, a_b[exp_idx*32 +: 32]} * {32'b0, b_b[exp_idx*32 +: 32]};
      q_b.push_back(e);
      a_b[exp_idx*32 +: 32] = $urandom | 32'd1;
      b_b[exp_idx*32 +: 32] = $urandom | 32'd1;
      n = 0;
      do begin @(negedge clk); n++; end while (done_b == 3'b0 && n < 30);
      if (g == 4) req_b = 3'b000;
      e = q_b.pop_front();
      eg = 3'b001 << e.idx;
      vecs++;
      if (done_b !== eg || n != LB || y_b !== e.prod) begin
        errs++;
        $display("FAIL cont_done %0d: done=%b after %0d y=%h, want %b after %0d y=%h",
                 g, done_b, n, y_b, eg, LB, e.prod);
      end
    end
  endtask

  task automatic test_reset_mid_exec;
    exp_t e;
    int   n;
    @(negedge clk);
    a_b[63:32] = 32'd11;
    b_b[63:32] = 32'd13;
    req_b = 3'b010;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt_b == 3'b0 && n < 30);
    vecs++;
    if (gnt_b !== 3'b010) begin errs++; $display("FAIL rme_gnt1: got %b want 010", gnt_b); end
    req_b = 3'b000;
    repeat (2) @(negedge clk);
    rst_b_n = 1'b0;
    #1;
    vecs++;
    if (done_b !== 3'b0 || y_b !== 64'd0 || busy_b !== 1'b0 || gnt_b !== 3'b0) begin
      errs++; $display("FAIL rme_abort: done=%b y=%h busy=%b gnt=%b want 0", done_b, y_b, busy_b, gnt_b);
    end
    repeat (2) @(negedge clk);
    rst_b_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vecs++;
      if (done_b !== 3'b0 || busy_b !== 1'b0) begin
        errs++; $display("FAIL rme_nodone cycle %0d: done=%b busy=%b want 0", i, done_b, busy_b);
      end
    end
    a_b = {32'd6, 32'd5, 32'd4};
    b_b = {32'd9, 32'd8, 32'd7};
    req_b = 3'b111;
    e.idx = 0; e.prod = 64'd28;
    q_b.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (gnt_b == 3'b0 && n < 30);
    req_b = 3'b000;
    vecs++;
    if (gnt_b !== 3'b001 || n != 1) begin
      errs++; $display("FAIL rme_regrant: got %b after %0d, want 001 after 1", gnt_b, n);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (done_b == 3'b0 && n < 30);
    e = q_b.pop_front();
    vecs++;
    if (done_b !== 3'b001 || y_b !== e.prod) begin
      errs++; $display("FAIL rme_done: done=%b y=%h want 001 %h", done_b, y_b, e.prod);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_width();
    test_back_to_back();
    test_withdrawal();
    test_contention();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
